// File: rtl/dkong3_busdec_pkg.sv
// Shared types and helpers for the dkong3 main-CPU bus decoder.
package dkong3_busdec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_BUSY,
        ST_DONE
    } wait_state_e;

    localparam int unsigned WCNT_W = 4;

    function automatic logic rgn_match(
        input logic [31:0] ab,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return (ab & mask) == base;
    endfunction

endpackage

// File: rtl/dkong3_latch259.sv
// Generic N-bit addressable latch (74LS259 style) with asynchronous reset.
module dkong3_latch259 #(
    parameter int unsigned  N    = 8,
    parameter logic [N-1:0] INIT = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [$clog2(N)-1:0] addr_i,
    input  logic                 d_i,
    output logic [N-1:0]         q_o
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (we_i) begin
            q_d[addr_i] = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/dkong3_busdec.sv
// Z80 memory-bus decoder: region selects, wait states, control latch bank,
// write strobes and VBLANK NMI generation.
module dkong3_busdec
    import dkong3_busdec_pkg::*;
#(
    parameter int unsigned           AW          = 16,
    parameter int unsigned           N_RGN       = 4,
    parameter logic [N_RGN*AW-1:0]   RGN_BASE    = {16'h8000, 16'h7400, 16'h7000, 16'h0000},
    parameter logic [N_RGN*AW-1:0]   RGN_MASK    = {16'hE000, 16'hFC00, 16'hFC00, 16'hC000},
    parameter logic [N_RGN*4-1:0]    RGN_WAIT    = {4'd1, 4'd0, 4'd0, 4'd2},
    parameter logic [N_RGN-1:0]      RGN_BUSY    = 4'b0100,
    parameter logic [AW-1:0]         LATCH_BASE  = 16'h7E80,
    parameter int unsigned           N_LATCH     = 8,
    parameter logic [N_LATCH-1:0]    LATCH_INIT  = '0,
    parameter int unsigned           NMI_CLR_BIT = 4,
    parameter logic [AW-1:0]         STB_BASE    = 16'h7D00,
    parameter int unsigned           N_STB       = 4
) (
    input  logic                I_CLK,
    input  logic                I_RESET_n,
    input  logic [AW-1:0]       I_AB,
    input  logic [7:0]          I_DB,
    input  logic                I_MREQ_n,
    input  logic                I_RFSH_n,
    input  logic                I_RD_n,
    input  logic                I_WR_n,
    input  logic                I_BUSY_n,
    input  logic                I_VBLK_n,
    output logic                O_WAIT_n,
    output logic                O_NMI_n,
    output logic [N_RGN-1:0]    O_CS_n,
    output logic [N_RGN-1:0]    O_RD_n,
    output logic [N_RGN-1:0]    O_WR_n,
    output logic [N_LATCH-1:0]  O_LATCH,
    output logic [N_STB-1:0]    O_STB,
    output logic [N_STB*8-1:0]  O_STB_D,
    output logic                O_SUB_RESET_n
);

    localparam int unsigned LA = $clog2(N_LATCH);

    logic               acc, acc_q, acc_start;
    logic               wr_acc, wr_acc_q, wr_start;
    logic [N_RGN-1:0]   sel;
    logic               hit;
    logic [WCNT_W-1:0]  wsel;
    logic               bsel;

    wait_state_e        state_q, state_d;
    logic [WCNT_W-1:0]  cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               wait_act;

    logic               latch_we;
    logic [N_LATCH-1:0] latch_q;
    logic               nmi_clr, vblk_q, vblk_fall, nmi_q;
    logic [N_STB-1:0]   stb_hit, stb_q;
    logic [N_STB*8-1:0] stb_data_q;
    logic               sub_rst_q;

    assign acc       = !I_MREQ_n && I_RFSH_n;
    assign acc_start = acc && !acc_q;
    assign wr_acc    = acc && !I_WR_n;
    assign wr_start  = wr_acc && !wr_acc_q;

    // First matching region claims the cycle, so overlapping maps stay one-hot.
    always_comb begin
        sel  = '0;
        hit  = 1'b0;
        wsel = '0;
        bsel = 1'b0;
        for (int unsigned i = 0; i < N_RGN; i++) begin
            if (!hit && rgn_match(32'(I_AB), 32'(RGN_BASE[i*AW +: AW]),
                                  32'(RGN_MASK[i*AW +: AW]))) begin
                hit    = 1'b1;
                sel[i] = 1'b1;
                wsel   = RGN_WAIT[i*WCNT_W +: WCNT_W];
                bsel   = RGN_BUSY[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        wait_act = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_start && hit) begin
                    busy_d = bsel;
                    if (wsel != '0) begin
                        state_d = ST_COUNT;
                        cnt_d   = wsel - WCNT_W'(1);
                    end else if (bsel) begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_COUNT: begin
                wait_act = 1'b1;
                if (cnt_q == '0) begin
                    state_d = busy_q ? ST_BUSY : ST_DONE;
                end else begin
                    cnt_d = cnt_q - WCNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (!I_BUSY_n) begin
                    wait_act = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (I_MREQ_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign latch_we  = wr_start && (I_AB[AW-1:LA] == LATCH_BASE[AW-1:LA]);
    assign nmi_clr   = latch_we && (I_AB[LA-1:0] == LA'(NMI_CLR_BIT)) && !I_DB[0];
    assign vblk_fall = vblk_q && !I_VBLK_n;

    dkong3_latch259 #(
        .N    (N_LATCH),
        .INIT (LATCH_INIT)
    ) u_latch (
        .clk_i  (I_CLK),
        .rst_ni (I_RESET_n),
        .we_i   (latch_we),
        .addr_i (I_AB[LA-1:0]),
        .d_i    (I_DB[0]),
        .q_o    (latch_q)
    );

    always_comb begin
        stb_hit = '0;
        for (int unsigned i = 0; i < N_STB; i++) begin
            stb_hit[i] = wr_start && (I_AB == STB_BASE + AW'(i << 7));
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            acc_q      <= 1'b0;
            wr_acc_q   <= 1'b0;
            vblk_q     <= 1'b1;
            nmi_q      <= 1'b0;
            stb_q      <= '0;
            stb_data_q <= '0;
            sub_rst_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            acc_q    <= acc;
            wr_acc_q <= wr_acc;
            vblk_q   <= I_VBLK_n;
            stb_q    <= stb_hit;
            for (int unsigned i = 0; i < N_STB; i++) begin
                if (stb_hit[i]) begin
                    stb_data_q[i*8 +: 8] <= I_DB;
                end
            end
            if (stb_hit[0]) begin
                sub_rst_q <= I_DB[0];
            end
            // A clear landing on the same edge as VBLANK suppresses the request.
            if (!latch_q[NMI_CLR_BIT] || nmi_clr) begin
                nmi_q <= 1'b0;
            end else if (vblk_fall) begin
                nmi_q <= 1'b1;
            end
        end
    end

    assign O_CS_n        = ~(sel & {N_RGN{acc && I_RESET_n}});
    assign O_RD_n        = O_CS_n | {N_RGN{I_RD_n}};
    assign O_WR_n        = O_CS_n | {N_RGN{I_WR_n || wait_act}};
    assign O_WAIT_n      = !wait_act;
    assign O_NMI_n       = !(nmi_q && latch_q[NMI_CLR_BIT]);
    assign O_LATCH       = latch_q;
    assign O_STB         = stb_q;
    assign O_STB_D       = stb_data_q;
    assign O_SUB_RESET_n = sub_rst_q;

endmodule
